// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: {bout, diff} = a - b - bin, one bit per cycle, LSB first.
// A single full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_full_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sa_n;
    logic [WIDTH-1:0] sb, sb_n;
    logic [WIDTH-1:0] sd, sd_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             br, br_n;
    logic [WIDTH-1:0] diff_n;
    logic             bout_n;
    logic             busy_n;
    logic             done_n;
    logic             d;
    logic             x;
    logic             y;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            sd    <= sd_n;
            cnt   <= cnt_n;
            br    <= br_n;
            diff  <= diff_n;
            bout  <= bout_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state, serial cell and result capture
    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        sd_n    = sd;
        cnt_n   = cnt;
        br_n    = br;
        diff_n  = diff;
        bout_n  = bout;
        x       = sa[0];
        y       = sb[0];
        d       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    br_n    = bin;
                    sd_n    = '0;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                d     = x ^ y ^ br;
                br_n  = (~x & y) | (~(x ^ y) & br);
                sd_n  = {d, sd[WIDTH-1:1]};
                sa_n  = sa >> 1;
                sb_n  = sb >> 1;
                cnt_n = cnt + CW'(1);
                // Last bit: publish the whole result at once, never partials
                if (cnt == CW'(WIDTH - 1)) begin
                    diff_n  = {d, sd[WIDTH-1:1]};
                    bout_n  = br_n;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench: an 8-bit instance for directed/random ops and a 3-bit
// instance for the exhaustive sweep, both checked against plain arithmetic.
module tb_serial_full_subtractor;

    typedef struct {
        logic [31:0] res;
        int          acc;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_q = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       bin3 = 1'b0;
    logic       busy3, done3, bout3;
    logic [2:0] diff3;

    item_t      q8[$];
    item_t      q3[$];
    int         free8 = 0;
    int         free3 = 0;
    logic [31:0] last8 = '0;
    logic [31:0] last3 = '0;

    serial_full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_full_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input int w, input int av, input int bv, input int bi);
        int m;
        m = (1 << (w + 1)) - 1;
        return 32'((av - bv - bi) & m);
    endfunction

    // Called at a negedge; the next posedge is the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        item_t it;
        while (cyc + 1 < free8) @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        it.res = model(8, int'(av), int'(bv), int'(bi));
        it.acc = cyc + 1;
        q8.push_back(it);
        free8 = cyc + 1 + 10;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic issue3(input logic [2:0] av, input logic [2:0] bv, input logic bi);
        item_t it;
        while (cyc + 1 < free3) @(negedge clk);
        start3 = 1'b1; a3 = av; b3 = bv; bin3 = bi;
        it.res = model(3, int'(av), int'(bv), int'(bi));
        it.acc = cyc + 1;
        q3.push_back(it);
        free3 = cyc + 1 + 5;
        @(negedge clk);
        start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
    endtask

    // Monitors: results on done, hold otherwise, cleared state after reset
    always @(negedge clk) begin
        item_t it;
        if (rst_q) begin
            chk("reset8", {20'd0, busy8, done8, bout8, 1'b0, diff8}, 32'd0);
            last8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) chk("extra_done8", 32'd1, 32'd0);
            else begin
                it = q8.pop_front();
                chk("result8", {23'd0, bout8, diff8}, it.res);
                chk("latency8", 32'(cyc), 32'(it.acc + 8));
                last8 = it.res;
            end
        end else begin
            chk("hold8", {23'd0, bout8, diff8}, last8);
        end
    end

    always @(negedge clk) begin
        item_t it;
        if (rst_q) begin
            chk("reset3", {25'd0, busy3, done3, bout3, 1'b0, diff3}, 32'd0);
            last3 = '0;
        end else if (done3) begin
            if (q3.size() == 0) chk("extra_done3", 32'd1, 32'd0);
            else begin
                it = q3.pop_front();
                chk("result3", {28'd0, bout3, diff3}, it.res);
                chk("latency3", 32'(cyc), 32'(it.acc + 3));
                last3 = it.res;
            end
        end else begin
            chk("hold3", {28'd0, bout3, diff3}, last3);
        end
    end

    initial begin
        // Reset with start held high on both instances
        start8 = 1'b1; start3 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        repeat (2) @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start3 = 1'b0;
        @(negedge clk);
        chk("idle_after_reset8", {31'd0, busy8}, 32'd0);
        chk("idle_after_reset3", {31'd0, busy3}, 32'd0);
        free8 = cyc + 1;
        free3 = cyc + 1;

        // Directed cases
        issue8(8'h5A, 8'h3C, 1'b0);
        issue8(8'h00, 8'h01, 1'b0);
        issue8(8'h80, 8'h7F, 1'b1);
        issue8(8'h00, 8'h00, 1'b1);

        // start while busy is ignored
        issue8(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_during_run8", {31'd0, busy8}, 32'd1);

        // Reset during the 4th RUN cycle discards the operation
        issue8(8'h33, 8'h11, 1'b0);
        while (cyc < q8[q8.size() - 1].acc + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q8.delete();
        q3.delete();
        rst = 1'b0;
        free8 = cyc + 1;
        free3 = cyc + 1;
        issue8(8'h09, 8'h02, 1'b1);

        // Random ops with occasional ignored start pulses mid-run
        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
            end
        end

        // Exhaustive 3-bit sweep, back to back
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            issue3(v[2:0], v[5:3], v[6]);
        end

        for (int i = 0; i < 200 && (q8.size() != 0 || q3.size() != 0); i++)
            @(negedge clk);
        chk("drained8", 32'(q8.size()), 32'd0);
        chk("drained3", 32'(q3.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
